// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_bist_ctrl_if.sv
// Bundle between the and3 BIST controller and its environment: run control,
// the pins of the and3 cell under test, and the result status.
interface gf180mcu_fd_sc_mcu7t5v0__and3_bist_ctrl_if;
    logic       START;
    logic       Z;
    logic       A1;
    logic       A2;
    logic       A3;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [7:0] FAIL_CNT;
    logic       FAIL_SEEN;
    logic [2:0] FAIL_VEC;

    modport master (
        input  START, Z,
        output A1, A2, A3, BUSY, DONE, PASS, FAIL_CNT, FAIL_SEEN, FAIL_VEC
    );

    modport slave (
        output START, Z,
        input  A1, A2, A3, BUSY, DONE, PASS, FAIL_CNT, FAIL_SEEN, FAIL_VEC
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_bist_ctrl.sv
// Exhaustive BIST for a 3-input AND cell: sweeps all 8 input patterns for
// N_PASSES passes, samples Z after a settle window and logs mismatches.
module gf180mcu_fd_sc_mcu7t5v0__and3_bist_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int N_PASSES   = 4
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__and3_bist_ctrl_if.master bist
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);
    localparam logic [7:0] LAST_PASS   = 8'(N_PASSES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] pattern_q, pattern_d;
    logic [3:0] w_q, w_d;
    logic [7:0] pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] fail_cnt_q, fail_cnt_d;
    logic       fail_seen_q, fail_seen_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic       mismatch;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            pattern_q   <= 3'd0;
            w_q         <= 4'd0;
            pass_q      <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_cnt_q  <= 8'd0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            w_q         <= w_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        w_d         = w_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_cnt_d  = fail_cnt_q;
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        mismatch    = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (bist.START) begin
                    state_d     = RUN;
                    pattern_d   = 3'd0;
                    w_d         = 4'd0;
                    pass_d      = 8'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_cnt_d  = 8'd0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = 3'd0;
                end
            end
            RUN: begin
                if (w_q < SETTLE_LAST) begin
                    w_d = w_q + 4'd1;
                end else begin
                    // Case inequality so an X/Z on the cell output is a failure.
                    mismatch = (bist.Z !== (&pattern_q));
                    if (mismatch) begin
                        fail_cnt_d = sat_inc8(fail_cnt_q);
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            fail_vec_d  = pattern_q;
                        end
                    end
                    w_d       = 4'd0;
                    pattern_d = pattern_q + 3'd1;
                    if (pattern_q == 3'd7) begin
                        pass_d = pass_q + 8'd1;
                        // Pattern wraps to 0 here, so the pins idle low in FINISH.
                        if (pass_q == LAST_PASS) begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bist.A1        = pattern_q[0];
    assign bist.A2        = pattern_q[1];
    assign bist.A3        = pattern_q[2];
    assign bist.BUSY      = busy_q;
    assign bist.DONE      = done_q;
    assign bist.PASS      = done_q && (fail_cnt_q == 8'd0);
    assign bist.FAIL_CNT  = fail_cnt_q;
    assign bist.FAIL_SEEN = fail_seen_q;
    assign bist.FAIL_VEC  = fail_vec_q;

endmodule
